// File: rtl/level_from_pulse.sv
// level_from_pulse: turns one-cycle event pulses into held level episodes, queueing pulses that arrive while busy.
// Optional timeout: define LEVEL_FROM_PULSE_TIMEOUT_EN to end an unacknowledged episode after HOLD_CYCLES.
module level_from_pulse #(
  parameter int unsigned HOLD_CYCLES = 16,
  parameter int unsigned GAP_CYCLES  = 1,
  parameter int unsigned PEND_W      = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              signal_pulse_i,
  input  logic              level_ack_i,
  output logic              signal_level_o,
  output logic [PEND_W-1:0] pending_o,
  output logic              overflow_o,
  output logic              timeout_o
);

  localparam int unsigned       GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    GAP
  } state_t;

  state_t            state_q;
  logic              level_q;
  logic              overflow_q;
  logic [PEND_W-1:0] pend_q;
  logic [GAP_W-1:0]  gap_cnt_q;

  logic              gap_last;
  logic              pend_any;
  logic              take_queued;
  logic              queue_pulse;
  logic              drop;
  logic [PEND_W-1:0] pend_next;
  logic              hold_expired;

  always_comb begin
    // NOTE: every signal gets a default first so no path through this block can infer a latch.
    gap_last    = 1'b0;
    pend_any    = 1'b0;
    take_queued = 1'b0;
    queue_pulse = 1'b0;
    drop        = 1'b0;
    pend_next   = pend_q;

    gap_last    = (state_q == GAP) && (gap_cnt_q == GAP_LAST);
    pend_any    = (pend_q != '0);
    take_queued = gap_last && pend_any;
    // A pulse in the last gap cycle with an empty queue starts the next episode directly.
    queue_pulse = signal_pulse_i &&
                  ((state_q == ACTIVE) || ((state_q == GAP) && !(gap_last && !pend_any)));
    drop        = queue_pulse && !take_queued && (pend_q == PEND_MAX);

    if (queue_pulse && !drop && !take_queued) begin
      pend_next = pend_q + PEND_W'(1);
    end else if (take_queued && !queue_pulse) begin
      pend_next = pend_q - PEND_W'(1);
    end
  end

`ifdef LEVEL_FROM_PULSE_TIMEOUT_EN
  localparam int unsigned       HOLD_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  logic [HOLD_W-1:0] hold_cnt_q;
  logic              timeout_q;

  // Ack in the final hold cycle takes priority, so no timeout is reported.
  assign hold_expired = (state_q == ACTIVE) && (hold_cnt_q == HOLD_LAST) && !level_ack_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hold_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      timeout_q <= hold_expired;
      if ((state_q == ACTIVE) && !level_ack_i && !hold_expired) begin
        hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
      end else begin
        hold_cnt_q <= '0;
      end
    end
  end

  assign timeout_o = timeout_q;
`else
  assign hold_expired = 1'b0;
  assign timeout_o    = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      level_q    <= 1'b0;
      pend_q     <= '0;
      overflow_q <= 1'b0;
      gap_cnt_q  <= '0;
    end else begin
      pend_q     <= pend_next;
      overflow_q <= drop;
      unique case (state_q)
        IDLE: begin
          if (signal_pulse_i) begin
            state_q <= ACTIVE;
            level_q <= 1'b1;
          end
        end
        ACTIVE: begin
          if (level_ack_i || hold_expired) begin
            state_q   <= GAP;
            level_q   <= 1'b0;
            gap_cnt_q <= '0;
          end
        end
        GAP: begin
          if (gap_last) begin
            gap_cnt_q <= '0;
            if (pend_any || signal_pulse_i) begin
              state_q <= ACTIVE;
              level_q <= 1'b1;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            gap_cnt_q <= gap_cnt_q + GAP_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          level_q <= 1'b0;
        end
      endcase
    end
  end

  assign signal_level_o = level_q;
  assign pending_o      = pend_q;
  assign overflow_o     = overflow_q;

endmodule

// File: tb/tb_level_from_pulse.sv
// Table-driven bench for level_from_pulse: two instances (short queue / single gap, and long gap).
// Expected outputs for each vector are queued when driven and compared half a cycle after the edge.
module tb_level_from_pulse;

`ifdef LEVEL_FROM_PULSE_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       p_a, k_a, p_b, k_b;
  logic       lvl_a, ovf_a, to_a;
  logic [1:0] pend_a;
  logic       lvl_b, ovf_b, to_b;
  logic [3:0] pend_b;

  always #5 clk_i = ~clk_i;

  level_from_pulse #(.HOLD_CYCLES(16), .GAP_CYCLES(1), .PEND_W(2)) u_dut_a (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .signal_pulse_i (p_a),
    .level_ack_i    (k_a),
    .signal_level_o (lvl_a),
    .pending_o      (pend_a),
    .overflow_o     (ovf_a),
    .timeout_o      (to_a)
  );

  level_from_pulse #(.HOLD_CYCLES(16), .GAP_CYCLES(3), .PEND_W(4)) u_dut_b (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .signal_pulse_i (p_b),
    .level_ack_i    (k_b),
    .signal_level_o (lvl_b),
    .pending_o      (pend_b),
    .overflow_o     (ovf_b),
    .timeout_o      (to_b)
  );

  typedef struct {
    logic       rst;
    logic       pulse;
    logic       ack;
    bit         sel_b;
    logic       lvl;
    logic [3:0] pend;
    logic       ovf;
    logic       tmo;
    string      name;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic void add(input logic r, input logic p, input logic a, input bit sb,
                              input logic l, input logic [3:0] pd, input logic o, input logic t,
                              input string n);
    vec_t v;
    v.rst = r; v.pulse = p; v.ack = a; v.sel_b = sb;
    v.lvl = l; v.pend = pd; v.ovf = o; v.tmo = t; v.name = n;
    tbl.push_back(v);
  endfunction

  // Called at a falling edge: drive, let one rising edge pass, compare at the next falling edge.
  task automatic apply(input vec_t v);
    vec_t e;
    rst_i = v.rst;
    p_a   = v.sel_b ? 1'b0 : v.pulse;
    k_a   = v.sel_b ? 1'b0 : v.ack;
    p_b   = v.sel_b ? v.pulse : 1'b0;
    k_b   = v.sel_b ? v.ack : 1'b0;
    exp_q.push_back(v);
    @(posedge clk_i);
    @(negedge clk_i);
    e = exp_q.pop_front();
    if (e.sel_b) begin
      check({e.name, ".level"},    {3'b0, lvl_b}, {3'b0, e.lvl});
      check({e.name, ".pending"},  pend_b,        e.pend);
      check({e.name, ".overflow"}, {3'b0, ovf_b}, {3'b0, e.ovf});
      check({e.name, ".timeout"},  {3'b0, to_b},  {3'b0, e.tmo});
    end else begin
      check({e.name, ".level"},    {3'b0, lvl_a},  {3'b0, e.lvl});
      check({e.name, ".pending"},  {2'b0, pend_a}, e.pend);
      check({e.name, ".overflow"}, {3'b0, ovf_a},  {3'b0, e.ovf});
      check({e.name, ".timeout"},  {3'b0, to_a},   {3'b0, e.tmo});
    end
  endtask

  initial begin
    rst_i = 1'b1; p_a = 1'b0; k_a = 1'b0; p_b = 1'b0; k_b = 1'b0;

    // Reset with a pulse present: the pulse must be ignored.
    add(1, 1, 0, 0, 0, 0, 0, 0, "reset_a");
    add(1, 1, 0, 1, 0, 0, 0, 0, "reset_b");

    // Single pulse, ack in the third high cycle; ack ignored in GAP and IDLE.
    add(0, 1, 0, 0, 1, 0, 0, 0, "ack.rise");
    add(0, 0, 0, 0, 1, 0, 0, 0, "ack.high2");
    add(0, 0, 0, 0, 1, 0, 0, 0, "ack.high3");
    add(0, 0, 1, 0, 0, 0, 0, 0, "ack.fall");
    add(0, 0, 1, 0, 0, 0, 0, 0, "ack.gap_ignored");
    add(0, 0, 1, 0, 0, 0, 0, 0, "ack.idle_ignored");

    // Three pulses, queue depth 2, ack three cycles after each rise.
    add(0, 1, 0, 0, 1, 0, 0, 0, "queue.rise1");
    add(0, 0, 0, 0, 1, 0, 0, 0, "queue.h");
    add(0, 1, 0, 0, 1, 1, 0, 0, "queue.pend1");
    add(0, 0, 0, 0, 1, 1, 0, 0, "queue.h");
    add(0, 1, 1, 0, 0, 2, 0, 0, "queue.ack1_pend2");
    add(0, 0, 0, 0, 1, 1, 0, 0, "queue.rise2");
    add(0, 0, 0, 0, 1, 1, 0, 0, "queue.h");
    add(0, 0, 0, 0, 1, 1, 0, 0, "queue.h");
    add(0, 0, 0, 0, 1, 1, 0, 0, "queue.h");
    add(0, 0, 1, 0, 0, 1, 0, 0, "queue.ack2");
    add(0, 0, 0, 0, 1, 0, 0, 0, "queue.rise3");
    add(0, 0, 0, 0, 1, 0, 0, 0, "queue.h");
    add(0, 0, 0, 0, 1, 0, 0, 0, "queue.h");
    add(0, 0, 0, 0, 1, 0, 0, 0, "queue.h");
    add(0, 0, 1, 0, 0, 0, 0, 0, "queue.ack3");
    add(0, 0, 0, 0, 0, 0, 0, 0, "queue.idle");
    add(0, 0, 0, 0, 0, 0, 0, 0, "queue.idle2");

    // Saturation with PEND_W=2: the 5th pulse is dropped; dequeue+pulse at max does not overflow.
    add(0, 1, 0, 0, 1, 0, 0, 0, "sat.rise");
    add(0, 1, 0, 0, 1, 1, 0, 0, "sat.p2");
    add(0, 1, 0, 0, 1, 2, 0, 0, "sat.p3");
    add(0, 1, 0, 0, 1, 3, 0, 0, "sat.p4");
    add(0, 1, 0, 0, 1, 3, 1, 0, "sat.p5_drop");
    add(0, 0, 0, 0, 1, 3, 0, 0, "sat.ovf_clear");
    add(0, 0, 1, 0, 0, 3, 0, 0, "sat.ack");
    add(0, 1, 0, 0, 1, 3, 0, 0, "sat.deq_plus_pulse");
    add(0, 0, 1, 0, 0, 3, 0, 0, "sat.ack");
    add(0, 0, 0, 0, 1, 2, 0, 0, "sat.deq");
    add(0, 0, 1, 0, 0, 2, 0, 0, "sat.ack");
    add(0, 0, 0, 0, 1, 1, 0, 0, "sat.deq");
    add(0, 0, 1, 0, 0, 1, 0, 0, "sat.ack");
    add(0, 0, 0, 0, 1, 0, 0, 0, "sat.deq");
    add(0, 0, 1, 0, 0, 0, 0, 0, "sat.ack");
    add(0, 0, 0, 0, 0, 0, 0, 0, "sat.idle");

    // No ack for 100 cycles: timeout after 16 high cycles, or held indefinitely without it.
    for (int k = 0; k < 100; k++)
      add(0, k == 0, 0, 0, TO_EN ? (k <= 15) : 1'b1, 0, 0, TO_EN && (k == 16), "hold");
    add(0, 0, 1, 0, 0, 0, 0, 0, "hold.ack");
    add(0, 0, 0, 0, 0, 0, 0, 0, "hold.idle");

    // Ack in the 16th high cycle: ack wins, no timeout.
    for (int k = 0; k <= 16; k++)
      add(0, k == 0, k == 16, 0, k < 16, 0, 0, 0, "ack_vs_timeout");
    add(0, 0, 0, 0, 0, 0, 0, 0, "ack_vs_timeout.idle");

    // Reset mid-episode with two queued pulses.
    add(0, 1, 0, 0, 1, 0, 0, 0, "midrst.rise");
    add(0, 1, 0, 0, 1, 1, 0, 0, "midrst.p");
    add(0, 1, 0, 0, 1, 2, 0, 0, "midrst.pend2");
    add(1, 1, 0, 0, 0, 0, 0, 0, "midrst.reset");
    add(0, 0, 0, 0, 0, 0, 0, 0, "midrst.idle");
    add(0, 1, 0, 0, 1, 0, 0, 0, "midrst.rise_again");
    add(0, 0, 1, 0, 0, 0, 0, 0, "midrst.ack");
    add(0, 0, 0, 0, 0, 0, 0, 0, "midrst.idle2");

    // Three-cycle gap instance: queued restart, last-gap-cycle direct pulse, gap ack ignored.
    add(0, 1, 0, 1, 1, 0, 0, 0, "gap3.rise");
    add(0, 0, 1, 1, 0, 0, 0, 0, "gap3.ack");
    add(0, 1, 0, 1, 0, 1, 0, 0, "gap3.queue");
    add(0, 0, 0, 1, 0, 1, 0, 0, "gap3.low3");
    add(0, 0, 0, 1, 1, 0, 0, 0, "gap3.deq_rise");
    add(0, 0, 1, 1, 0, 0, 0, 0, "gap3.ack2");
    add(0, 0, 0, 1, 0, 0, 0, 0, "gap3.low");
    add(0, 0, 0, 1, 0, 0, 0, 0, "gap3.low");
    add(0, 1, 0, 1, 1, 0, 0, 0, "gap3.direct_rise");
    add(0, 0, 1, 1, 0, 0, 0, 0, "gap3.ack3");
    add(0, 0, 1, 1, 0, 0, 0, 0, "gap3.ack_ignored");
    add(0, 0, 0, 1, 0, 0, 0, 0, "gap3.low");
    add(0, 0, 0, 1, 0, 0, 0, 0, "gap3.to_idle");
    add(0, 0, 0, 1, 0, 0, 0, 0, "gap3.idle");
    add(0, 1, 0, 1, 1, 0, 0, 0, "gap3.idle_rise");
    add(0, 0, 1, 1, 0, 0, 0, 0, "gap3.ack4");
    add(0, 0, 0, 1, 0, 0, 0, 0, "gap3.low");
    add(0, 0, 0, 1, 0, 0, 0, 0, "gap3.low");
    add(0, 0, 0, 1, 0, 0, 0, 0, "gap3.to_idle2");
    add(0, 0, 1, 1, 0, 0, 0, 0, "gap3.idle_ack_ignored");

    @(negedge clk_i);
    foreach (tbl[i]) apply(tbl[i]);

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard: %0d entries left, expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
